// File: rtl/cpu_program_loader.sv
// Byte-stream program/data loader feeding an IMEM and a DMEM, holding the CPU in halt during a burst.
// Optional build macro LOADER_CHECKSUM_EN adds the running XOR checksum register; otherwise checksum reads 0.
module cpu_program_loader #(
   parameter int ADDR_W      = 5,
   parameter int INSTR_BYTES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   input  logic                       is_instruction,
   input  logic [ADDR_W-1:0]          start_address,
   input  logic [7:0]                 load_byte,
   input  logic                       load_valid,
   output logic                       load_ready,
   output logic                       cpu_halt,
   output logic                       load_done,
   output logic [ADDR_W:0]            load_count,
   output logic                       load_ovf,
   output logic                       load_partial,
   output logic [7:0]                 checksum,
   input  logic [ADDR_W-1:0]          imem_addr,
   output logic [8*INSTR_BYTES-1:0]   imem_rdata,
   input  logic [ADDR_W-1:0]          dmem_raddr,
   output logic [7:0]                 dmem_rdata,
   input  logic                       dmem_we,
   input  logic [ADDR_W-1:0]          dmem_waddr,
   input  logic [7:0]                 dmem_wdata,
   output logic                       state_dbg
);
   localparam int IW    = 8 * INSTR_BYTES;
   localparam int DEPTH = 1 << ADDR_W;
   localparam int BI_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

   // Handshake: a byte transfers on a rising edge where load_valid and load_ready are both high;
   // load_ready never depends on load_valid, and an offered byte that is not accepted is simply lost.

   typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              load_q, load_d;
   logic              tgt_q, tgt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BI_W-1:0]   idx_q, idx_d;
   logic [IW-1:0]     pack_q, pack_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              partial_q, partial_d;
   logic              done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        checksum_q, checksum_d;
`endif

   logic [IW-1:0]     imem_mem [DEPTH];
   logic [7:0]        dmem_mem [DEPTH];
   logic [IW-1:0]     imem_rdata_q;
   logic [7:0]        dmem_rdata_q;
   logic [IW-1:0]     word_w;
   logic              ready_c, accept_c, imem_wr, ld_dmem_wr;

   assign ready_c  = (state_q == S_LOAD) && load && !count_q[ADDR_W];
   assign accept_c = load_valid && ready_c;

   always_comb begin
      state_d    = state_q;
      load_d     = load;
      tgt_d      = tgt_q;
      addr_d     = addr_q;
      idx_d      = idx_q;
      pack_d     = pack_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      partial_d  = partial_q;
      done_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      imem_wr    = 1'b0;
      ld_dmem_wr = 1'b0;
      word_w     = pack_q;
      word_w[8*int'(idx_q) +: 8] = load_byte;
      case (state_q)
         S_IDLE: begin
            if (load && !load_q) begin
               state_d    = S_LOAD;
               tgt_d      = is_instruction;
               addr_d     = start_address;
               idx_d      = '0;
               pack_d     = '0;
               count_d    = '0;
               ovf_d      = 1'b0;
               partial_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               checksum_d = 8'h00;
`endif
            end
         end
         S_LOAD: begin
            if (!load) begin
               // Leftover bytes of an unfinished instruction are dropped, only flagged.
               state_d   = S_IDLE;
               done_d    = 1'b1;
               partial_d = (idx_q != '0);
            end else begin
               if (load_valid && count_q[ADDR_W]) ovf_d = 1'b1;
               if (accept_c) begin
`ifdef LOADER_CHECKSUM_EN
                  checksum_d = checksum_q ^ load_byte;
`endif
                  if (tgt_q) begin
                     pack_d = word_w;
                     if (idx_q == BI_W'(INSTR_BYTES - 1)) begin
                        imem_wr = 1'b1;
                        idx_d   = '0;
                        addr_d  = addr_q + 1'b1;
                        count_d = count_q + 1'b1;
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                  end else begin
                     ld_dmem_wr = 1'b1;
                     addr_d     = addr_q + 1'b1;
                     count_d    = count_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         load_q     <= 1'b0;
         tgt_q      <= 1'b0;
         addr_q     <= '0;
         idx_q      <= '0;
         pack_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         partial_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         checksum_q <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         tgt_q      <= tgt_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         pack_q     <= pack_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         partial_q  <= partial_d;
         done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   // Loader and CPU never write DMEM in the same cycle: the loader only writes while halted.
   always_ff @(posedge clk) begin
      if (imem_wr) imem_mem[addr_q] <= word_w;
      if (ld_dmem_wr) dmem_mem[addr_q] <= load_byte;
      else if (dmem_we && !cpu_halt) dmem_mem[dmem_waddr] <= dmem_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         imem_rdata_q <= '0;
         dmem_rdata_q <= '0;
      end else begin
         imem_rdata_q <= imem_mem[imem_addr];
         dmem_rdata_q <= dmem_mem[dmem_raddr];
      end
   end

   assign load_ready   = ready_c;
   assign cpu_halt     = (state_q == S_LOAD);
   assign state_dbg    = (state_q == S_LOAD);
   assign load_done    = done_q;
   assign load_count   = count_q;
   assign load_ovf     = ovf_q;
   assign load_partial = partial_q;
   assign imem_rdata   = imem_rdata_q;
   assign dmem_rdata   = dmem_rdata_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum     = checksum_q;
`else
   assign checksum     = 8'h00;
`endif
endmodule

// File: tb/tb_cpu_program_loader.sv
// Randomized bench for cpu_program_loader against a burst-level memory model.
module tb_cpu_program_loader;
   localparam int AW = 5, IB = 2, IW = 16, DEPTH = 32;

   logic          clk, reset, load, is_instruction, load_valid, load_ready, cpu_halt, load_done;
   logic          load_ovf, load_partial, dmem_we, state_dbg;
   logic [AW-1:0] start_address, imem_addr, dmem_raddr, dmem_waddr;
   logic [7:0]    load_byte, checksum, dmem_rdata, dmem_wdata;
   logic [AW:0]   load_count;
   logic [IW-1:0] imem_rdata;

   cpu_program_loader #(.ADDR_W(AW), .INSTR_BYTES(IB)) dut (
      .clk(clk), .reset(reset), .load(load), .is_instruction(is_instruction),
      .start_address(start_address), .load_byte(load_byte), .load_valid(load_valid),
      .load_ready(load_ready), .cpu_halt(cpu_halt), .load_done(load_done),
      .load_count(load_count), .load_ovf(load_ovf), .load_partial(load_partial),
      .checksum(checksum), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata), .dmem_we(dmem_we),
      .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   logic [IW-1:0] imem_m [DEPTH];
   logic [7:0]    dmem_m [DEPTH];
   logic [31:0]   exp_q[$];
   logic [7:0]    byte_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One burst of byte_q into the chosen memory; expectations come from the burst-level rules.
   task automatic run_burst(input logic tgt, input logic [AW-1:0] start);
      int         n, cap, acc, words;
      logic [7:0] cks;
      logic [IW-1:0] w;
      n     = byte_q.size();
      cap   = tgt ? DEPTH * IB : DEPTH;
      acc   = (n < cap) ? n : cap;
      words = tgt ? acc / IB : acc;
      cks   = 8'h00;
      for (int i = 0; i < acc; i++) cks ^= byte_q[i];
`ifndef LOADER_CHECKSUM_EN
      cks = 8'h00;
`endif
      @(negedge clk);
      dmem_we = 1'b0; load = 1'b1; is_instruction = tgt; start_address = start;
      load_valid = 1'b1; load_byte = 8'($urandom);
      @(negedge clk);
      check_eq("halt_rise", cpu_halt, 1);
      is_instruction = ~tgt; start_address = AW'($urandom); load_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            load_valid = 1'b0;
            @(negedge clk);
         end
         check_eq("ready", load_ready, (i < cap) ? 1 : 0);
         load_byte = byte_q[i]; load_valid = 1'b1;
         dmem_we = 1'($urandom_range(0, 1)); dmem_waddr = AW'($urandom); dmem_wdata = 8'($urandom);
         @(negedge clk);
      end
      check_eq("ready_end", load_ready, (n < cap) ? 1 : 0);
      load = 1'b0; load_valid = 1'b1; load_byte = 8'($urandom); dmem_we = 1'b0;
      @(negedge clk);
      check_eq("done", load_done, 1);
      check_eq("halt_fall", cpu_halt, 0);
      check_eq("count", load_count, words);
      check_eq("ovf", load_ovf, (n > cap) ? 1 : 0);
      check_eq("partial", load_partial, (tgt && (acc % IB) != 0) ? 1 : 0);
      check_eq("checksum", checksum, cks);
      load_valid = 1'b0;
      @(negedge clk);
      check_eq("done_once", load_done, 0);
      check_eq("count_hold", load_count, words);
      for (int k = 0; k < words; k++) begin
         if (tgt) begin
            w = '0;
            for (int j = 0; j < IB; j++) w |= IW'(byte_q[k*IB + j]) << (8*j);
            imem_m[(int'(start) + k) % DEPTH] = w;
         end else begin
            dmem_m[(int'(start) + k) % DEPTH] = byte_q[k];
         end
      end
      byte_q.delete();
   endtask

   task automatic verify_mem();
      for (int a = 0; a < DEPTH; a++) begin
         imem_addr = AW'(a); dmem_raddr = AW'(a);
         exp_q.push_back(32'(imem_m[a]));
         exp_q.push_back(32'(dmem_m[a]));
         @(negedge clk);
         check_eq("imem_rd", imem_rdata, exp_q.pop_front());
         check_eq("dmem_rd", dmem_rdata, exp_q.pop_front());
      end
   endtask

   task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
      dmem_we = 1'b1; dmem_waddr = a; dmem_raddr = a; dmem_wdata = d;
      @(negedge clk);
      check_eq("rdw_old", dmem_rdata, dmem_m[a]);
      dmem_we = 1'b0; dmem_m[a] = d;
      @(negedge clk);
      check_eq("cpu_wr", dmem_rdata, d);
   endtask

   task automatic push_random(input int n);
      for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] s;
      reset = 1'b1; load = 1'b0; is_instruction = 1'b0; start_address = '0;
      load_byte = '0; load_valid = 1'b0; imem_addr = '0; dmem_raddr = '0;
      dmem_we = 1'b0; dmem_waddr = '0; dmem_wdata = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_halt", cpu_halt, 0);
      check_eq("rst_done", load_done, 0);
      check_eq("rst_count", load_count, 0);
      check_eq("rst_ovf", load_ovf, 0);
      check_eq("rst_partial", load_partial, 0);
      check_eq("rst_checksum", checksum, 0);
      check_eq("rst_ready", load_ready, 0);
      check_eq("rst_imem_rd", imem_rdata, 0);
      check_eq("rst_dmem_rd", dmem_rdata, 0);
      reset = 1'b0;

      push_random(DEPTH * IB); run_burst(1'b1, 5'd0);
      push_random(DEPTH);      run_burst(1'b0, 5'd7);
      verify_mem();

      byte_q = '{8'h34, 8'h12, 8'h78, 8'h56}; run_burst(1'b1, 5'd3);
      byte_q = '{8'hAA, 8'hBB};               run_burst(1'b0, 5'd31);
      verify_mem();

      push_random(DEPTH + 1); run_burst(1'b0, AW'($urandom));
      push_random(3);         run_burst(1'b1, AW'($urandom));
      verify_mem();

      byte_q = '{8'h01, 8'h02, 8'h04}; run_burst(1'b0, AW'($urandom));
      for (int r = 0; r < 6; r++) begin
         push_random($urandom_range(0, 70));
         run_burst(1'($urandom_range(0, 1)), AW'($urandom));
      end
      verify_mem();

      for (int r = 0; r < 4; r++) cpu_write(AW'($urandom), 8'($urandom));

      s = AW'($urandom);
      @(negedge clk);
      load = 1'b1; is_instruction = 1'b0; start_address = s; load_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         byte_q.push_back(8'($urandom));
         load_byte = byte_q[k]; load_valid = 1'b1;
         @(negedge clk);
      end
      reset = 1'b1; load = 1'b0; load_valid = 1'b0;
      @(negedge clk);
      check_eq("abort_halt", cpu_halt, 0);
      check_eq("abort_done", load_done, 0);
      check_eq("abort_count", load_count, 0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("abort_no_done", load_done, 0);
      for (int k = 0; k < 3; k++) dmem_m[(int'(s) + k) % DEPTH] = byte_q[k];
      byte_q.delete();
      verify_mem();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
